mem_access_ctrl: RTL and testbench

Bus sequencer between the SLC-3 datapath's MAR/MDR logic and the Mem2IO/SRAM path. It accepts one read or write request at a time and drives the address, OE and WE strobes and write data toward the memory/IO mapper. It holds those strobes for a fixed number of access cycles, captures read data, and returns a one-cycle completion pulse. This replaces ad-hoc wait states in the control FSM with a single handshake.

---
 rtl/mem_ctrl_pkg.sv | 18 +
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SLC-3 memory access sequencer.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Memory-mapped IO location that may bypass the SRAM wait states.
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    // The access counter is 4 bits, which bounds the wait-state setting.
    localparam int CNT_W           = 4;
    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = 15;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-request bus sequencer between MAR/MDR logic and the Mem2IO/SRAM path.
// Holds address/strobes for WAIT_CYCLES cycles, captures read data, pulses done.
// Optional macro FAST_IO_EN: accesses to IO_ADDR take a single access cycle.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter load value: the last access cycle is the one where the counter reads 0.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  load_cnt;

    // Pick the access length for the incoming request (shortened for the IO location if enabled).
    always_comb begin
`ifdef FAST_IO_EN
        load_cnt = (req_addr == ADDR_W'(IO_ADDR)) ? '0 : CNT_LOAD;
`else
        load_cnt = CNT_LOAD;
`endif
    end

    // Next-state logic: every output has its own register so nothing toward the mapper is decoded.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        oe_d    = oe_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    cnt_d   = load_cnt;
                    busy_d  = 1'b1;
                    oe_d    = ~req_we;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                oe_d    = 1'b0;
                we_d    = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access immediately and clears everything.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_oe    = oe_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a WAIT_CYCLES=2 instance driven with directed and
// random transactions, plus a WAIT_CYCLES=1 instance for back-to-back reads.
module tb_mem_access_ctrl;

    localparam int WAIT_A = 2;
    localparam int WAIT_B = 1;

    logic        Clk;
    logic        Reset;

    logic        reqA, reqWeA, busyA, doneA, memOeA, memWeA;
    logic [15:0] reqAddrA, reqWdataA, rdataA, memAddrA, memWdataA, memRdataA;

    logic        reqB, reqWeB, busyB, doneB, memOeB, memWeB;
    logic [15:0] reqAddrB, reqWdataB, rdataB, memAddrB, memWdataB, memRdataB;

    int          checks;
    int          failures;
    logic [15:0] rdataModel;

    mem_access_ctrl #(.WAIT_CYCLES(WAIT_A), .ADDR_W(16), .DATA_W(16)) dutA (
        .Clk(Clk), .Reset(Reset),
        .req(reqA), .req_we(reqWeA), .req_addr(reqAddrA), .req_wdata(reqWdataA),
        .busy(busyA), .done(doneA), .rdata(rdataA),
        .mem_addr(memAddrA), .mem_oe(memOeA), .mem_we(memWeA),
        .mem_wdata(memWdataA), .mem_rdata(memRdataA)
    );

    mem_access_ctrl #(.WAIT_CYCLES(WAIT_B), .ADDR_W(16), .DATA_W(16)) dutB (
        .Clk(Clk), .Reset(Reset),
        .req(reqB), .req_we(reqWeB), .req_addr(reqAddrB), .req_wdata(reqWdataB),
        .busy(busyB), .done(doneB), .rdata(rdataB),
        .mem_addr(memAddrB), .mem_oe(memOeB), .mem_we(memWeB),
        .mem_wdata(memWdataB), .mem_rdata(memRdataB)
    );

    // Free-running 10-unit clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Number of strobe cycles an access to this address should take.
    function automatic int expLatency(input logic [15:0] addr);
        int lat;
        lat = WAIT_A;
`ifdef FAST_IO_EN
        if (addr == 16'hFFFF) lat = 1;
`endif
        return lat;
    endfunction

    // One complete transaction on instance A, checked cycle by cycle against the reference.
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] memData, input bit pokeBusy);
        int lat;
        lat = expLatency(addr);
        @(negedge Clk);
        reqA      = 1'b1;
        reqWeA    = we;
        reqAddrA  = addr;
        reqWdataA = wdata;
        memRdataA = memData;
        @(posedge Clk);
        #1;
        reqA      = 1'b0;
        reqWeA    = 1'($urandom);
        reqAddrA  = 16'($urandom);
        reqWdataA = 16'($urandom);
        if (pokeBusy) begin
            reqA     = 1'b1;
            reqWeA   = 1'b0;
            reqAddrA = 16'h0030;
        end
        for (int i = 1; i <= lat; i++) begin
            checkOutput("acc_busy", busyA, 1);
            checkOutput("acc_done", doneA, 0);
            checkOutput("acc_oe", memOeA, !we);
            checkOutput("acc_we", memWeA, we);
            checkOutput("acc_addr", memAddrA, addr);
            checkOutput("acc_wdata", memWdataA, wdata);
            @(posedge Clk);
            #1;
        end
        reqA = 1'b0;
        if (!we) rdataModel = memData;
        checkOutput("done_pulse", doneA, 1);
        checkOutput("done_busy", busyA, 1);
        checkOutput("done_oe", memOeA, 0);
        checkOutput("done_we", memWeA, 0);
        checkOutput("done_addr", memAddrA, addr);
        checkOutput("done_wdata", memWdataA, wdata);
        checkOutput("done_rdata", rdataA, rdataModel);
        @(posedge Clk);
        #1;
        checkOutput("post_done", doneA, 0);
        checkOutput("post_busy", busyA, 0);
        checkOutput("post_oe", memOeA, 0);
        checkOutput("post_we", memWeA, 0);
        checkOutput("post_rdata", rdataA, rdataModel);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rdataModel = 16'h0000;
        Reset      = 1'b0;
        reqA = 1'b0; reqWeA = 1'b0; reqAddrA = '0; reqWdataA = '0; memRdataA = '0;
        reqB = 1'b0; reqWeB = 1'b0; reqAddrB = '0; reqWdataB = '0; memRdataB = '0;

        $display("[TB] reset checks");
        #1 Reset = 1'b1;
        #1;
        checkOutput("rst_busyA", busyA, 0);
        checkOutput("rst_doneA", doneA, 0);
        checkOutput("rst_oeA", memOeA, 0);
        checkOutput("rst_weA", memWeA, 0);
        checkOutput("rst_addrA", memAddrA, 0);
        checkOutput("rst_wdataA", memWdataA, 0);
        checkOutput("rst_rdataA", rdataA, 0);
        checkOutput("rst_busyB", busyB, 0);
        checkOutput("rst_rdataB", rdataB, 0);
        @(negedge Clk);
        Reset = 1'b0;

        $display("[TB] directed read and write");
        applyStimulus(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        applyStimulus(1'b1, 16'h0020, 16'h1234, 16'h5555, 1'b1);
        @(posedge Clk);
        #1;
        checkOutput("ignored_req_busy", busyA, 0);
        checkOutput("ignored_req_done", doneA, 0);
        checkOutput("ignored_req_addr", memAddrA, 16'h0020);

        $display("[TB] reset during write");
        @(negedge Clk);
        reqA = 1'b1; reqWeA = 1'b1; reqAddrA = 16'h0040; reqWdataA = 16'hAAAA;
        @(posedge Clk);
        #1;
        reqA = 1'b0;
        checkOutput("midrst_we_before", memWeA, 1);
        Reset = 1'b1;
        #1;
        rdataModel = 16'h0000;
        checkOutput("midrst_we", memWeA, 0);
        checkOutput("midrst_busy", busyA, 0);
        checkOutput("midrst_rdata", rdataA, 0);
        checkOutput("midrst_addr", memAddrA, 0);
        checkOutput("midrst_done", doneA, 0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            checkOutput("midrst_no_done", doneA, 0);
            checkOutput("midrst_idle", busyA, 0);
        end
        applyStimulus(1'b0, 16'h0050, 16'h0000, 16'h7777, 1'b0);

        $display("[TB] IO address read");
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 16'h03FF, 1'b0);

        $display("[TB] random transactions");
        for (int n = 0; n < 24; n++) begin
            logic        we;
            logic [15:0] addr;
            we   = 1'($urandom);
            addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            applyStimulus(we, addr, 16'($urandom), 16'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge Clk);
        end

        $display("[TB] back-to-back reads with one wait cycle");
        @(negedge Clk);
        reqB = 1'b1; reqWeB = 1'b0; reqAddrB = 16'h0001; memRdataB = 16'hA001;
        @(posedge Clk);
        #1;
        reqAddrB = 16'h0002;
        checkOutput("b2b_first_oe", memOeB, 1);
        checkOutput("b2b_first_addr", memAddrB, 16'h0001);
        checkOutput("b2b_first_done", doneB, 0);
        @(posedge Clk);
        #1;
        checkOutput("b2b_first_donepulse", doneB, 1);
        checkOutput("b2b_first_rdata", rdataB, 16'hA001);
        checkOutput("b2b_first_oe_off", memOeB, 0);
        memRdataB = 16'hB002;
        @(posedge Clk);
        #1;
        checkOutput("b2b_gap_busy", busyB, 0);
        checkOutput("b2b_gap_done", doneB, 0);
        checkOutput("b2b_gap_oe", memOeB, 0);
        @(posedge Clk);
        #1;
        reqB = 1'b0;
        checkOutput("b2b_second_oe", memOeB, 1);
        checkOutput("b2b_second_addr", memAddrB, 16'h0002);
        checkOutput("b2b_second_busy", busyB, 1);
        @(posedge Clk);
        #1;
        checkOutput("b2b_second_donepulse", doneB, 1);
        checkOutput("b2b_second_rdata", rdataB, 16'hB002);
        @(posedge Clk);
        #1;
        checkOutput("b2b_end_done", doneB, 0);
        checkOutput("b2b_end_busy", busyB, 0);
        checkOutput("b2b_end_rdata", rdataB, 16'hB002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
